// File: rtl/rip_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between two line-refill
// requesters; one burst in flight at a time, R beats routed to the owner.
module rip_axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [7:0]            req_len_1,
  input  logic                  req_valid_2,
  output logic                  req_ready_2,
  input  logic [ADDR_WIDTH-1:0] req_addr_2,
  input  logic [7:0]            req_len_2,
  output logic                  rsp_valid_1,
  input  logic                  rsp_ready_1,
  output logic                  rsp_valid_2,
  input  logic                  rsp_ready_2,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  protocol_err,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer occurs on a rising clk edge where valid && ready;
  // valid never waits on ready, and payload is stable while valid && !ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;      // 1: requester 2 wins a tie
  logic                  owner_q, owner_d;  // 1: requester 2 owns the burst
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic                  perr_q, perr_d;

  logic                  grant_1, grant_2;
  logic                  r_fire;
  logic [ID_WIDTH-1:0]   owner_id;
  logic                  unused_rresp0;

  assign grant_1  = req_valid_1 & (~req_valid_2 | ~ptr_q);
  assign grant_2  = req_valid_2 & (~req_valid_1 |  ptr_q);
  assign r_fire   = m_rvalid & m_rready;
  assign owner_id = {{(ID_WIDTH-1){1'b0}}, owner_q};

  assign m_arid       = owner_id;
  assign m_araddr     = addr_q;
  assign m_arlen      = len_q;
  assign m_arsize     = 3'($clog2(DATA_WIDTH / 8));
  assign m_arburst    = 2'b01;
  assign rsp_data     = m_rdata;
  assign rsp_last     = m_rlast;
  assign rsp_err      = m_rresp[1];
  assign protocol_err = perr_q;
  assign dbg_state_o  = state_q;
  assign unused_rresp0 = m_rresp[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    perr_d      = perr_q;
    req_ready_1 = 1'b0;
    req_ready_2 = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    rsp_valid_1 = 1'b0;
    rsp_valid_2 = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_1 = grant_1;
        req_ready_2 = grant_2;
        if (grant_1) begin
          addr_d  = req_addr_1;
          len_d   = req_len_1;
          owner_d = 1'b0;
          state_d = ADDR;
        end else if (grant_2) begin
          addr_d  = req_addr_2;
          len_d   = req_len_2;
          owner_d = 1'b1;
          state_d = ADDR;
        end
      end

      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        rsp_valid_1 = m_rvalid & ~owner_q;
        rsp_valid_2 = m_rvalid &  owner_q;
        m_rready    = owner_q ? rsp_ready_2 : rsp_ready_1;
        if (r_fire) begin
          beat_d = beat_q + 8'd1;
          // Errors are only flagged; the burst still ends on RLAST alone.
          if ((m_rid != owner_id) || (m_rlast != (beat_q == len_q))) begin
            perr_d = 1'b1;
          end
          if (m_rlast) begin
            ptr_d   = ~owner_q;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rip_axi_read_arbiter.sv
// Directed bench for rip_axi_read_arbiter: AXI slave model, scoreboard of
// expected AR commands and R beats, assertion-based checks.
module tb_rip_axi_read_arbiter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;

  logic        clk;
  logic        rstn;
  logic        req_valid_1, req_ready_1, req_valid_2, req_ready_2;
  logic [31:0] req_addr_1, req_addr_2;
  logic [7:0]  req_len_1, req_len_2;
  logic        rsp_valid_1, rsp_ready_1, rsp_valid_2, rsp_ready_2;
  logic [31:0] rsp_data;
  logic        rsp_last, rsp_err;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic        protocol_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  // {rsp_valid_2, rsp_valid_1, rsp_last, rsp_err, rsp_data}
  logic [35:0] exp_q[$];
  // {arid, arlen, araddr}
  logic [43:0] ar_exp_q[$];

  int ar_stall = 0;
  int early    = -1;

  rip_axi_read_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_addr_1(req_addr_1), .req_len_1(req_len_1),
    .req_valid_2(req_valid_2), .req_ready_2(req_ready_2),
    .req_addr_2(req_addr_2), .req_len_2(req_len_2),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_valid_2(rsp_valid_2), .rsp_ready_2(rsp_ready_2),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .protocol_err(protocol_err), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_checks++;
    n_err++;
    $error("FAIL %s: observed=no event expected=event", tag);
  endtask

  function automatic logic [31:0] mk_data(input logic [31:0] a, input int b);
    return (a + 32'(b) * 32'd4) ^ 32'h5A5A_0000;
  endfunction

  task automatic push_exp(input int n, input logic [31:0] a, input logic [7:0] len,
                          input int nbeats);
    ar_exp_q.push_back({4'(n - 1), len, a});
    for (int i = 0; i < nbeats; i++) begin
      exp_q.push_back({(n == 2), (n == 1), (i == nbeats - 1), (a[11:8] == 4'h3),
                       mk_data(a, i)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int n, input logic [31:0] a, input logic [7:0] len);
    if (n == 1) begin
      req_valid_1 = 1'b1; req_addr_1 = a; req_len_1 = len;
    end else begin
      req_valid_2 = 1'b1; req_addr_2 = a; req_len_2 = len;
    end
  endtask

  task automatic wait_accept(input int n, input bit drop);
    int t = 0;
    forever begin
      @(negedge clk);
      if ((n == 1) ? req_ready_1 : req_ready_2) break;
      t++;
      if (t > 400) begin
        fail("accept_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    if (drop) begin
      if (n == 1) req_valid_1 = 1'b0;
      else        req_valid_2 = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || ar_exp_q.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) fail("drain_timeout");
  endtask

  task automatic wait_beats_left(input int left);
    int t = 0;
    while (exp_q.size() > left && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) fail("beat_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {req_ready_1, req_ready_2, m_arvalid, m_rready}, 4'b0000);
    chk({tag, "_rsp"}, {rsp_valid_1, rsp_valid_2, protocol_err}, 3'b000);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
    chk({tag, "_ar"}, {m_arid, m_arlen, m_araddr}, 44'd0);
  endtask

  task automatic hold_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    req_valid_1 = 1'b0; req_valid_2 = 1'b0;
    exp_q.delete();
    ar_exp_q.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // ---------------- AXI slave model ----------------
  logic        s_active;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  logic [3:0]  s_id;
  int          s_beat, ar_wait;
  logic        ar_fire, r_fire;

  task automatic present_beat();
    m_rvalid = 1'b1;
    m_rid    = s_id;
    m_rdata  = mk_data(s_addr, s_beat);
    m_rresp  = (s_addr[11:8] == 4'h3) ? 2'b10 : 2'b00;
    m_rlast  = (s_beat == int'(s_len)) || (s_beat == early);
  endtask

  initial begin
    m_arready = 0; m_rvalid = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    s_active = 0; s_addr = 0; s_len = 0; s_id = 0; s_beat = 0; ar_wait = 0;
    forever begin
      @(negedge clk);
      ar_fire = m_arvalid & m_arready;
      r_fire  = m_rvalid & m_rready;
      if (ar_fire) begin
        s_addr = m_araddr; s_len = m_arlen; s_id = m_arid;
      end
      @(posedge clk); #1;
      if (!rstn) begin
        s_active = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; ar_wait = 0;
      end else begin
        if (r_fire) begin
          if (m_rlast) begin
            s_active = 0; m_rvalid = 0; m_rlast = 0;
          end else begin
            s_beat++;
            present_beat();
          end
        end
        if (ar_fire) begin
          s_active = 1; s_beat = 0; ar_wait = 0;
          present_beat();
        end
        m_arready = 1'b0;
        if (!s_active && m_arvalid) begin
          if (ar_wait >= ar_stall) m_arready = 1'b1;
          else ar_wait++;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [43:0] ea;
    logic [35:0] eb;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (m_arvalid && m_arready) begin
          if (ar_exp_q.size() == 0) fail("ar_unexpected");
          else begin
            ea = ar_exp_q.pop_front();
            chk("ar_id_len_addr", {m_arid, m_arlen, m_araddr}, ea);
            chk("ar_size_burst", {m_arsize, m_arburst}, {3'd2, 2'd1});
          end
        end
        if (m_rvalid)
          chk("rready_follows_owner", m_rready,
              (rsp_valid_1 & rsp_ready_1) | (rsp_valid_2 & rsp_ready_2));
        if (m_rvalid && m_rready) begin
          if (exp_q.size() == 0) fail("beat_unexpected");
          else begin
            eb = exp_q.pop_front();
            chk("r_beat", {rsp_valid_2, rsp_valid_1, rsp_last, rsp_err, rsp_data}, eb);
          end
        end
        if (req_valid_1 && req_valid_2)
          chk("single_grant", req_ready_1 & req_ready_2, 1'b0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [31:0] a1[3];
  logic [31:0] a2[3];

  initial begin
    a1 = '{32'h1000, 32'h1100, 32'h1200};
    a2 = '{32'h2000, 32'h2300, 32'h2400};
    rstn = 1'b0;
    req_valid_1 = 0; req_valid_2 = 0;
    req_addr_1 = 0; req_addr_2 = 0; req_len_1 = 0; req_len_2 = 0;
    rsp_ready_1 = 1; rsp_ready_2 = 1;

    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    release_reset();

    // Single request from requester 1
    push_exp(1, 32'h0000_0040, 8'd3, 4);
    @(posedge clk); #1;
    drive_req(1, 32'h0000_0040, 8'd3);
    wait_accept(1, 1);
    @(negedge clk);
    chk("t1_arvalid_next", m_arvalid, 1'b1);
    chk("t1_state_addr", dbg_state, ST_ADDR);
    wait_drain();
    @(negedge clk);
    chk("t1_idle_after_last", dbg_state, ST_IDLE);

    // Simultaneous requests after reset: 1,2,1,2,1,2
    hold_reset();
    release_reset();
    for (int k = 0; k < 3; k++) begin
      push_exp(1, a1[k], 8'd1, 2);
      push_exp(2, a2[k], 8'd1, 2);
    end
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          drive_req(1, a1[k], 8'd1);
          wait_accept(1, k == 2);
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          drive_req(2, a2[k], 8'd1);
          wait_accept(2, k == 2);
        end
      end
    join
    wait_drain();

    // Response backpressure on requester 2 while requester 1 waits
    push_exp(2, 32'h2800, 8'd3, 4);
    push_exp(1, 32'h1800, 8'd0, 1);
    @(posedge clk); #1;
    drive_req(2, 32'h2800, 8'd3);
    wait_accept(2, 1);
    wait_beats_left(4);
    @(posedge clk); #1;
    rsp_ready_2 = 1'b0;
    drive_req(1, 32'h1800, 8'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rready_low", m_rready, 1'b0);
      chk("bp_no_grant_1", req_ready_1, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready_2 = 1'b1;
    wait_accept(1, 1);
    wait_drain();

    // AR stall: payload stable while m_arready low
    ar_stall = 10;
    push_exp(1, 32'h1a00, 8'd1, 2);
    @(posedge clk); #1;
    drive_req(1, 32'h1a00, 8'd1);
    wait_accept(1, 1);
    repeat (10) begin
      @(negedge clk);
      chk("ar_stall_hold", {m_arvalid, m_arready, m_arlen, m_araddr},
          {1'b1, 1'b0, 8'd1, 32'h1a00});
    end
    wait_drain();
    ar_stall = 0;

    // Early RLAST on second beat of a len-3 burst
    chk("perr_before", protocol_err, 1'b0);
    early = 1;
    push_exp(2, 32'h2c00, 8'd3, 2);
    @(posedge clk); #1;
    drive_req(2, 32'h2c00, 8'd3);
    wait_accept(2, 1);
    wait_drain();
    @(negedge clk);
    chk("perr_raised", protocol_err, 1'b1);
    chk("perr_state_idle", dbg_state, ST_IDLE);
    early = -1;
    repeat (3) @(negedge clk);
    chk("perr_sticky", protocol_err, 1'b1);

    // Reset mid-burst, then requester 2 served normally
    push_exp(1, 32'h1e00, 8'd3, 4);
    @(posedge clk); #1;
    drive_req(1, 32'h1e00, 8'd3);
    wait_accept(1, 1);
    wait_beats_left(2);
    hold_reset();
    @(negedge clk);
    chk_reset_outputs("midburst_reset");
    release_reset();
    push_exp(2, 32'h2e00, 8'd1, 2);
    @(posedge clk); #1;
    drive_req(2, 32'h2e00, 8'd1);
    wait_accept(2, 1);
    wait_drain();
    @(negedge clk);
    chk("after_reset_perr", protocol_err, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rip_axi_read_arbiter.md
# rip_axi_read_arbiter

Arbitrates the single AXI4 read channel of the memory management unit between two line-refill requesters: requester 1 is the data-port miss path and requester 2 is the read-only port miss path. It sequences one burst at a time (AR then R), routes read beats back to the owning requester, and alternates grants round-robin so neither port can starve or deadlock the other. It sits between the cache miss engines and the MMU's AXI master read channel; the write channels bypass it.

## Interface
- ADDR_WIDTH, 32, address width of requests and ARADDR
- DATA_WIDTH, 32, R data width; ARSIZE = log2(DATA_WIDTH/8)
- ID_WIDTH, 4, AXI ID width; requester 1 uses ID 0, requester 2 uses ID 1
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid_1 / req_valid_2  in  1  refill request pending
- req_ready_1 / req_ready_2  out  1  request accepted this cycle
- req_addr_1 / req_addr_2  in  ADDR_WIDTH  burst start address (line aligned)
- req_len_1 / req_len_2  in  8  beats minus one (AXI LEN encoding)
- rsp_valid_1 / rsp_valid_2  out  1  read beat for this requester
- rsp_ready_1 / rsp_ready_2  in  1  requester accepts beat
- rsp_data  out  DATA_WIDTH  beat data, shared by both requesters
- rsp_last  out  1  last beat of burst
- rsp_err  out  1  RRESP[1] of current beat (SLVERR/DECERR)
- m_arid  out  ID_WIDTH;  m_araddr  out  ADDR_WIDTH;  m_arlen  out  8;  m_arsize  out  3;  m_arburst  out  2 (always INCR = 2'b01);  m_arvalid  out  1;  m_arready  in  1
- m_rid  in  ID_WIDTH;  m_rdata  in  DATA_WIDTH;  m_rresp  in  2;  m_rlast  in  1;  m_rvalid  in  1;  m_rready  out  1
- protocol_err  out  1  sticky: RID mismatch or RLAST at wrong beat; cleared only by reset

## Operation
- States: IDLE, ADDR, DATA. One outstanding burst at most.
- IDLE: grant = requester with req_valid; if both valid, grant the one not served last (priority pointer). Pointer resets to favour requester 1.
- req_ready_N = (state == IDLE) & grant == N (combinational). On req_valid_N & req_ready_N: latch addr, len, owner = N; go to ADDR.
- ADDR: m_arvalid = 1; m_araddr/m_arlen/m_arid from latched values; held stable until m_arready. On handshake: beat counter := 0, go to DATA.
- DATA: rsp_valid_owner = m_rvalid; other rsp_valid = 0; m_rready = rsp_ready_owner; rsp_data/rsp_last/rsp_err pass through from m_rdata/m_rlast/m_rresp[1].
- Each R handshake increments beat counter (8 bits). On the handshake with m_rlast: go to IDLE, pointer := other requester.
- protocol_err set if, on an R handshake, m_rid != owner ID, or (m_rlast != (beat counter == latched len)). Routing is unchanged on error; the burst ends only on m_rlast.
- Error responses (rsp_err) do not alter sequencing; the requester decides what to do with them.
- Requesters hold req_* stable while req_valid and not req_ready; the arbiter does not require this after acceptance.
- A requester waiting on its own response never blocks the other's grant after its burst ends: pointer always flips on completion.

## Timing
- Reset values: req_ready_* 0, m_arvalid 0, m_rready 0, rsp_valid_* 0, protocol_err 0, state IDLE, pointer = requester 1, m_ar* payload 0.
- Async reset mid-burst: immediately back to IDLE, all outputs at reset values; the in-flight AXI burst is abandoned (slave is reset by the same rstn).
- Request accepted in cycle t (IDLE) -> m_arvalid high in cycle t+1.
- m_arready in cycle a -> m_rready may be driven from cycle a+1.
- Last R handshake in cycle r -> IDLE in cycle r+1; next req_ready can assert in r+1 (one idle-free turnaround).
- Minimum burst occupancy: 3 cycles + (len+1) beats with zero-wait slave.
- Both valid in same IDLE cycle: exactly one req_ready asserts; never both.
- m_rvalid in IDLE or ADDR: ignored, m_rready 0 (no protocol_err flagged).

## Test plan
- Single request 1: addr 0x0000_0040, len 3 -> ARID 0, ARLEN 3, ARSIZE 2, ARBURST 1; 4 beats only on rsp_valid_1, rsp_last on 4th; next req_ready one cycle after last beat.
- Simultaneous requests after reset: both valid continuously, 3 bursts each -> grant order 1,2,1,2,1,2; ARIDs 0,1,0,1,0,1.
- Backpressure: rsp_ready_2 low for 5 cycles mid-burst -> m_rready low, data held by VIP, no beats lost; req_valid_1 meanwhile not granted until burst 2 ends.
- AR stall: m_arready held low 10 cycles -> m_arvalid, m_araddr, m_arlen stable throughout.
- Protocol error: slave returns RLAST on beat 2 of len 3 -> protocol_err rises on that beat and stays 1; state returns to IDLE.
- Reset mid-burst after 2 of 4 beats -> all outputs at reset values next cycle; subsequent request from 2 served normally with ID 1.
